// File: rtl/hc_mmio_csr_pkg.sv
// Shared HardCloud CSR package: CCI-P MMIO channel types, buffer descriptors,
// register offsets, control codes and the control FSM state encoding.
package hc_mmio_csr_pkg;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef logic [63:0] t_hc_address;

    typedef struct packed {
        t_hc_address address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [1:0] {
        S_CTL_RESET = 2'd0,
        S_CTL_IDLE  = 2'd1,
        S_CTL_RUN   = 2'd2,
        S_CTL_DONE  = 2'd3
    } t_ctl_state;

    localparam logic [11:0] HC_DFH         = 12'h000;
    localparam logic [11:0] HC_AFU_ID_L    = 12'h008;
    localparam logic [11:0] HC_AFU_ID_H    = 12'h010;
    localparam logic [11:0] HC_STATUS      = 12'h100;
    localparam logic [11:0] HC_DSM_BASE    = 12'h110;
    localparam logic [11:0] HC_CONTROL     = 12'h118;
    localparam logic [11:0] HC_BUFFER_BASE = 12'h120;

    localparam logic [31:0] HC_CONTROL_ASSERT_RST   = 32'h0;
    localparam logic [31:0] HC_CONTROL_DEASSERT_RST = 32'h1;
    localparam logic [31:0] HC_CONTROL_START        = 32'h3;
    localparam logic [31:0] HC_CONTROL_STOP         = 32'h7;

    // Feature type AFU in [63:60], end-of-list in bit 40.
    localparam logic [63:0] HC_DFH_VALUE = 64'h1000_0100_0000_0000;

    typedef struct packed {
        logic       hit;
        logic       is_size;
        logic [2:0] idx;
    } t_buf_slot;

    // Descriptor i occupies 0x120+0x10*i (address) and 0x128+0x10*i (size).
    function automatic t_buf_slot hc_buf_decode(input logic [11:0] off,
                                                input int unsigned n_bufs);
        t_buf_slot   r;
        logic [11:0] rel;
        rel       = off - HC_BUFFER_BASE;
        r.hit     = (off >= HC_BUFFER_BASE) && (rel[2:0] == 3'b000) &&
                    ({24'b0, rel[11:4]} < n_bufs);
        r.is_size = rel[3];
        r.idx     = rel[6:4];
        return r;
    endfunction

endpackage

// File: rtl/hc_mmio_csr_if.sv
// CCI-P MMIO bundle: c0 request channel in, c2 read-response channel out.
interface hc_mmio_csr_if;
    import hc_mmio_csr_pkg::*;

    t_if_ccip_c0_Rx rx_mmio;
    t_if_ccip_c2_Tx tx_mmio;

    modport master (output rx_mmio, input tx_mmio);
    modport slave  (input rx_mmio, output tx_mmio);
endinterface

// File: rtl/hc_mmio_rd_mux.sv
// Combinational MMIO read-data selection. Define HC_CSR_READBACK_EN to make
// the DSM base, control word and buffer descriptors readable.
module hc_mmio_rd_mux
    import hc_mmio_csr_pkg::*;
#(
    parameter int unsigned N_BUFFERS = 3,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
) (
    input  logic [11:0]                offset_i,
    input  logic                       hit_i,
    input  t_ctl_state                 state_i,
    input  logic                       running_i,
    input  logic                       afu_reset_i,
    input  logic [63:0]                dsm_base_i,
    input  logic [31:0]                ctl_i,
    input  t_hc_buffer [N_BUFFERS-1:0] buffers_i,
    output logic [63:0]                data_o
);

`ifdef HC_CSR_READBACK_EN
    t_buf_slot slot;
    assign slot = hc_buf_decode(offset_i, N_BUFFERS);
`else
    logic unused_rb;
    assign unused_rb = ^{dsm_base_i, ctl_i, buffers_i};
`endif

    always_comb begin
        data_o = '0;
        if (hit_i) begin
            case (offset_i)
                HC_DFH:      data_o = HC_DFH_VALUE;
                HC_AFU_ID_L: data_o = AFU_ID_L;
                HC_AFU_ID_H: data_o = AFU_ID_H;
                HC_STATUS:   data_o = {60'b0, state_i, running_i, afu_reset_i};
`ifdef HC_CSR_READBACK_EN
                HC_DSM_BASE: data_o = dsm_base_i;
                HC_CONTROL:  data_o = {32'b0, ctl_i};
`endif
                default:     data_o = '0;
            endcase
`ifdef HC_CSR_READBACK_EN
            for (int i = 0; i < N_BUFFERS; i++) begin
                if (slot.hit && slot.idx == 3'(i)) begin
                    data_o = slot.is_size ? {32'b0, buffers_i[i].size}
                                          : buffers_i[i].address;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/hc_mmio_csr.sv
// HardCloud AFU CSR block: MMIO-mapped DSM/buffer descriptors and control FSM.
// Optional register readback is enabled by defining HC_CSR_READBACK_EN.
module hc_mmio_csr
    import hc_mmio_csr_pkg::*;
#(
    parameter int unsigned N_BUFFERS = 3,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    hc_mmio_csr_if.slave               mmio,
    output logic [63:0]                dsm_base,
    output t_hc_buffer [N_BUFFERS-1:0] buffers,
    output logic                       afu_reset,
    output logic                       start,
    output logic                       running,
    input  logic                       done
);

    t_if_ccip_c0_Rx rx;
    logic           in_range;
    logic [11:0]    off;
    logic           wr_en;
    logic [63:0]    wr_data;
    logic           ctl_wr;
    logic           cfg_wr;
    t_buf_slot      slot;
    logic           cmd_assert, cmd_deassert, cmd_start, cmd_stop;

    t_ctl_state                 state_q, state_d;
    logic                       start_q;
    logic [63:0]                dsm_base_q;
    t_hc_buffer [N_BUFFERS-1:0] buffers_q;
    logic [31:0]                ctl_q;
    t_if_ccip_c2_Tx             tx_q;
    logic [63:0]                rd_data;

    assign rx       = mmio.rx_mmio;
    assign in_range = (rx.hdr.address[15:10] == 6'b0);
    assign off      = {rx.hdr.address[9:0], 2'b00};
    assign wr_en    = rx.mmioWrValid && in_range;
    assign wr_data  = rx.data[63:0];
    assign slot     = hc_buf_decode(off, N_BUFFERS);

    assign ctl_wr       = wr_en && (off == HC_CONTROL);
    assign cmd_assert   = ctl_wr && (wr_data[31:0] == HC_CONTROL_ASSERT_RST);
    assign cmd_deassert = ctl_wr && (wr_data[31:0] == HC_CONTROL_DEASSERT_RST);
    assign cmd_start    = ctl_wr && (wr_data[31:0] == HC_CONTROL_START);
    assign cmd_stop     = ctl_wr && (wr_data[31:0] == HC_CONTROL_STOP);

    // Descriptors are frozen while the datapath is running.
    assign cfg_wr = wr_en && (state_q != S_CTL_RUN);

    logic unused_rx;
    assign unused_rx = ^{rx.data[511:64], rx.hdr.length, rx.hdr.rsvd, rx.rspValid};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CTL_RESET;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= (state_q == S_CTL_IDLE) && (state_d == S_CTL_RUN);
        end
    end

    // Host commands are evaluated before done, so STOP/ASSERT_RST win a tie.
    always_comb begin
        state_d = state_q;
        if (cmd_assert) begin
            state_d = S_CTL_RESET;
        end else begin
            case (state_q)
                S_CTL_RESET: if (cmd_deassert) state_d = S_CTL_IDLE;
                S_CTL_IDLE:  if (cmd_start)    state_d = S_CTL_RUN;
                S_CTL_DONE:  if (cmd_start)    state_d = S_CTL_RUN;
                S_CTL_RUN: begin
                    if (cmd_stop)  state_d = S_CTL_IDLE;
                    else if (done) state_d = S_CTL_DONE;
                end
                default:     state_d = S_CTL_RESET;
            endcase
        end
    end

    always_comb begin
        afu_reset = (state_q == S_CTL_RESET);
        running   = (state_q == S_CTL_RUN);
        start     = start_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsm_base_q <= '0;
            buffers_q  <= '0;
            ctl_q      <= '0;
        end else begin
            if (ctl_wr) ctl_q <= wr_data[31:0];
            if (cfg_wr && off == HC_DSM_BASE) dsm_base_q <= wr_data;
            for (int i = 0; i < N_BUFFERS; i++) begin
                if (cfg_wr && slot.hit && slot.idx == 3'(i)) begin
                    if (slot.is_size) buffers_q[i].size    <= wr_data[31:0];
                    else              buffers_q[i].address <= wr_data;
                end
            end
        end
    end

    hc_mmio_rd_mux #(
        .N_BUFFERS (N_BUFFERS),
        .AFU_ID_L  (AFU_ID_L),
        .AFU_ID_H  (AFU_ID_H)
    ) u_rd_mux (
        .offset_i    (off),
        .hit_i       (in_range),
        .state_i     (state_q),
        .running_i   (running),
        .afu_reset_i (afu_reset),
        .dsm_base_i  (dsm_base_q),
        .ctl_i       (ctl_q),
        .buffers_i   (buffers_q),
        .data_o      (rd_data)
    );

    // Single register stage gives the fixed one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q.mmioRdValid <= 1'b0;
        end else begin
            tx_q.mmioRdValid <= rx.mmioRdValid;
            if (rx.mmioRdValid) begin
                tx_q.hdr.tid <= rx.hdr.tid;
                tx_q.data    <= rd_data;
            end
        end
    end

    assign mmio.tx_mmio = tx_q;
    assign dsm_base     = dsm_base_q;
    assign buffers      = buffers_q;

endmodule

// File: tb/tb_hc_mmio_csr.sv
// Scoreboarded bench for hc_mmio_csr; read expectations queue up at issue time
// and are matched (tid, data, response cycle) by the response monitor.
module tb_hc_mmio_csr;
    import hc_mmio_csr_pkg::*;

    localparam int unsigned NB      = 3;
    localparam logic [63:0] ID_L    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H    = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_0000;
`ifdef HC_CSR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic                done  = 1'b0;
    logic [63:0]         dsm_base;
    t_hc_buffer [NB-1:0] buffers;
    logic                afu_reset, start, running;

    hc_mmio_csr_if mmio_if ();

    hc_mmio_csr #(
        .N_BUFFERS (NB),
        .AFU_ID_L  (ID_L),
        .AFU_ID_H  (ID_H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mmio      (mmio_if),
        .dsm_base  (dsm_base),
        .buffers   (buffers),
        .afu_reset (afu_reset),
        .start     (start),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    t_hc_buffer [NB-1:0] buf_m;
    logic [63:0]         dsm_m;

    always @(negedge clk) begin
        if (mmio_if.tx_mmio.mmioRdValid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: got tid %0d data %h, required no response",
                         mmio_if.tx_mmio.hdr.tid, mmio_if.tx_mmio.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mmio_if.tx_mmio.hdr.tid !== e.tid || mmio_if.tx_mmio.data !== e.data || cyc != e.cyc)
                    $display("FAIL rd_%s: got tid %0d data %h cyc %0d, required tid %0d data %h cyc %0d",
                             e.name, mmio_if.tx_mmio.hdr.tid, mmio_if.tx_mmio.data, cyc, e.tid, e.data, e.cyc);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [17:0] ba, input logic [63:0] d);
        mmio_if.rx_mmio.hdr.address = ba[17:2];
        mmio_if.rx_mmio.data        = {448'b0, d};
        mmio_if.rx_mmio.mmioWrValid = 1'b1;
        tick();
        mmio_if.rx_mmio.mmioWrValid = 1'b0;
    endtask

    task automatic rd(input string name, input logic [8:0] tid, input logic [17:0] ba,
                      input logic [63:0] exp_d);
        exp_t e;
        e.name = name;
        e.tid  = tid;
        e.data = exp_d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        mmio_if.rx_mmio.hdr.address = ba[17:2];
        mmio_if.rx_mmio.hdr.tid     = tid;
        mmio_if.rx_mmio.mmioRdValid = 1'b1;
        tick();
        mmio_if.rx_mmio.mmioRdValid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({afu_reset, start, running, mmio_if.tx_mmio.mmioRdValid} !== 4'b1000)
            $display("FAIL reset_ctl: got {afu_reset,start,running,rdvalid}=%b required 1000",
                     {afu_reset, start, running, mmio_if.tx_mmio.mmioRdValid});
        else n_pass++;
        n_checks++;
        if (dsm_base !== 64'h0 || buffers !== '0)
            $display("FAIL reset_data: got dsm %h bufs %h required all zero", dsm_base, buffers);
        else n_pass++;
        buf_m = '0;
        dsm_m = '0;
        reset = 1'b0;
        tick();
        rd("status_reset", 9'd1, 18'h100, 64'h1);
        rd("dfh", 9'd2, 18'h000, DFH_EXP);
        rd("afu_id_h", 9'd3, 18'h010, ID_H);
    endtask

    task automatic test_deassert;
        wr(18'h118, 64'h1);
        n_checks++;
        if (afu_reset !== 1'b0) $display("FAIL deassert: got afu_reset %b required 0", afu_reset);
        else n_pass++;
        rd("status_idle", 9'd4, 18'h100, 64'h4);
        wr(18'h1118, 64'h0);
        n_checks++;
        if (afu_reset !== 1'b0) $display("FAIL out_of_range_wr: got afu_reset %b required 0", afu_reset);
        else n_pass++;
        rd("out_of_range_rd", 9'd12, 18'h1000, 64'h0);
    endtask

    task automatic test_buffers;
        wr(18'h130, 64'hDEAD_BEEF_0000_1000);
        wr(18'h138, 64'hFFFF_FFFF_0000_0400);
        buf_m[1] = '{address: 64'hDEAD_BEEF_0000_1000, size: 32'h400};
        wr(18'h120, 64'h1111_2222_3333_4440);
        buf_m[0].address = 64'h1111_2222_3333_4440;
        wr(18'h148, 64'h80);
        buf_m[2].size = 32'h80;
        wr(18'h150, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(18'h158, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(18'h110, 64'hABCD_0000_0000_0040);
        dsm_m = 64'hABCD_0000_0000_0040;
        n_checks++;
        if (buffers[1] !== {64'hDEAD_BEEF_0000_1000, 32'h400})
            $display("FAIL buf1: got %h required %h", buffers[1], {64'hDEAD_BEEF_0000_1000, 32'h400});
        else n_pass++;
        n_checks++;
        if (buffers !== buf_m) $display("FAIL buf_all: got %h required %h", buffers, buf_m);
        else n_pass++;
        n_checks++;
        if (dsm_base !== dsm_m) $display("FAIL dsm_wr: got %h required %h", dsm_base, dsm_m);
        else n_pass++;
        rd("rb_buf1_addr", 9'd7, 18'h130, RB ? 64'hDEAD_BEEF_0000_1000 : 64'h0);
        rd("rb_buf1_size", 9'd8, 18'h138, RB ? 64'h400 : 64'h0);
        rd("rb_dsm", 9'd9, 18'h110, RB ? dsm_m : 64'h0);
        rd("rb_ctl", 9'd10, 18'h118, RB ? 64'h1 : 64'h0);
    endtask

    task automatic test_run;
        wr(18'h118, 64'h3);
        n_checks++;
        if ({start, running} !== 2'b11) $display("FAIL start_hi: got {start,running}=%b required 11", {start, running});
        else n_pass++;
        tick();
        n_checks++;
        if ({start, running} !== 2'b01) $display("FAIL start_lo: got {start,running}=%b required 01", {start, running});
        else n_pass++;
        rd("status_run", 9'd13, 18'h100, 64'hA);
        wr(18'h120, 64'h5555_5555_5555_5550);
        wr(18'h110, 64'h7777_0000_0000_0000);
        n_checks++;
        if (buffers !== buf_m || dsm_base !== dsm_m)
            $display("FAIL run_lock: got bufs %h dsm %h required bufs %h dsm %h", buffers, dsm_base, buf_m, dsm_m);
        else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (running !== 1'b0) $display("FAIL done_run: got running %b required 0", running);
        else n_pass++;
        rd("status_done", 9'd14, 18'h100, 64'hC);
    endtask

    task automatic test_ctl_priority;
        wr(18'h118, 64'h3);
        n_checks++;
        if (running !== 1'b1) $display("FAIL restart: got running %b required 1", running);
        else n_pass++;
        done = 1'b1;
        wr(18'h118, 64'h7);
        done = 1'b0;
        rd("stop_over_done", 9'd15, 18'h100, 64'h4);
        wr(18'h118, 64'h5);
        rd("ignored_code", 9'd16, 18'h100, 64'h4);
        wr(18'h118, 64'h3);
        done = 1'b1;
        wr(18'h118, 64'h0);
        done = 1'b0;
        n_checks++;
        if (afu_reset !== 1'b1) $display("FAIL rst_over_done: got afu_reset %b required 1", afu_reset);
        else n_pass++;
        rd("status_rst_cmd", 9'd17, 18'h100, 64'h1);
        wr(18'h118, 64'h1);
    endtask

    task automatic test_back_to_back;
        rd("b2b_tid5", 9'd5, 18'h008, ID_L);
        rd("b2b_tid6", 9'd6, 18'h200, 64'h0);
        wr(18'h110, 64'h0000_0001_2345_6780);
        dsm_m = 64'h0000_0001_2345_6780;
        rd("wr_then_rd", 9'd11, 18'h110, RB ? dsm_m : 64'h0);
        n_checks++;
        if (dsm_base !== dsm_m) $display("FAIL b2b_dsm: got %h required %h", dsm_base, dsm_m);
        else n_pass++;
    endtask

    task automatic test_reset_in_run;
        wr(18'h118, 64'h3);
        reset = 1'b1;
        mmio_if.rx_mmio.hdr.address = 16'h0040;
        mmio_if.rx_mmio.hdr.tid     = 9'd9;
        mmio_if.rx_mmio.mmioRdValid = 1'b1;
        tick();
        mmio_if.rx_mmio.mmioRdValid = 1'b0;
        n_checks++;
        if ({running, afu_reset, mmio_if.tx_mmio.mmioRdValid} !== 3'b010)
            $display("FAIL rst_in_run: got {running,afu_reset,rdvalid}=%b required 010",
                     {running, afu_reset, mmio_if.tx_mmio.mmioRdValid});
        else n_pass++;
        n_checks++;
        if (dsm_base !== 64'h0 || buffers !== '0)
            $display("FAIL rst_in_run_data: got dsm %h bufs %h required all zero", dsm_base, buffers);
        else n_pass++;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        rd("status_after_rst", 9'd18, 18'h100, 64'h1);
    endtask

    initial begin
        mmio_if.rx_mmio = '0;
        test_reset();
        test_deassert();
        test_buffers();
        test_run();
        test_ctl_priority();
        test_back_to_back();
        test_reset_in_run();
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rd_missing: got %0d outstanding responses, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
